// File: rtl/audio_pwm_out.sv
// Audio PWM output stage. A free-running counter compares against a double-buffered duty value.
// pwm_out and audio_sd_out are registered one cycle behind the counter and mute_in. New samples take effect only at a period boundary.
module audio_pwm_out #(
   parameter int PWM_BITS = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] sample_in,
   input  logic        sample_valid_in,
   input  logic [1:0]  vol_shift_in,
   input  logic        mute_in,
   output logic        pwm_out,
   output logic        audio_sd_out,
   output logic        sample_taken_out,
   output logic        overrun_out
);

   localparam logic [PWM_BITS-1:0] CNT_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};
   localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

   logic [PWM_BITS-1:0] count_q, count_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [15:0]         pending_q, pending_d;
   logic                pending_full_q, pending_full_d;
   logic                pwm_q, pwm_d;
   logic                sd_q, sd_d;
   logic                taken_q, taken_d;
   logic                overrun_q, overrun_d;

   logic                load;
   logic [15:0]         shifted;
   logic [15:0]         offset;
   logic [PWM_BITS-1:0] conv_duty;
   logic                unused_lsbs;

   // Sign-preserving attenuation, then offset-binary so the midscale of the signed range maps to half duty.
   always_comb begin
      shifted   = $signed(pending_q) >>> vol_shift_in;
      offset    = {~shifted[15], shifted[14:0]};
      conv_duty = offset[15 -: PWM_BITS];
   end

   assign unused_lsbs = ^offset;

   assign load = (count_q == CNT_MAX) && pending_full_q;

   always_comb begin
      count_d        = count_q + CNT_ONE;
      duty_d         = duty_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      overrun_d      = overrun_q;
      taken_d        = load;

      if (load) begin
         duty_d         = conv_duty;
         pending_full_d = 1'b0;
      end

      // A strobe on the load cycle refills the buffer the load just emptied, so it is not an overrun.
      if (sample_valid_in) begin
         pending_d      = sample_in;
         pending_full_d = 1'b1;
         if (pending_full_q && !load) begin
            overrun_d = 1'b1;
         end
      end

      pwm_d = !mute_in && (count_q < duty_q);
      sd_d  = !mute_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_q        <= '0;
         duty_q         <= DUTY_MID;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         pwm_q          <= 1'b0;
         sd_q           <= 1'b0;
         taken_q        <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         count_q        <= count_d;
         duty_q         <= duty_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         pwm_q          <= pwm_d;
         sd_q           <= sd_d;
         taken_q        <= taken_d;
         overrun_q      <= overrun_d;
      end
   end

   assign pwm_out          = pwm_q;
   assign audio_sd_out     = sd_q;
   assign sample_taken_out = taken_q;
   assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out at PWM_BITS=8; cnt tracks the counter value the DUT should hold at each falling edge.
module tb_audio_pwm_out;

   logic        clk_in;
   logic        rst_in;
   logic [15:0] sample_in;
   logic        sample_valid_in;
   logic [1:0]  vol_shift_in;
   logic        mute_in;
   logic        pwm_out;
   logic        audio_sd_out;
   logic        sample_taken_out;
   logic        overrun_out;

   int n_tests;
   int n_fail;
   int cnt;
   int hi;
   int tk;

   audio_pwm_out #(.PWM_BITS(8)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .sample_in       (sample_in),
      .sample_valid_in (sample_valid_in),
      .vol_shift_in    (vol_shift_in),
      .mute_in         (mute_in),
      .pwm_out         (pwm_out),
      .audio_sd_out    (audio_sd_out),
      .sample_taken_out(sample_taken_out),
      .overrun_out     (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_in);
      cnt = (cnt + 1) % 256;
   endtask

   task automatic wait_to(input int target);
      for (int i = 0; i < 300 && cnt != target; i++) begin
         step();
      end
   endtask

   task automatic send(input logic [15:0] v);
      sample_in       = v;
      sample_valid_in = 1'b1;
      step();
      sample_valid_in = 1'b0;
   endtask

   // Call with cnt==1: the 256 samples then cover the period that started at counter 0.
   task automatic measure(output int h, output int t);
      h = 0;
      t = 0;
      for (int i = 0; i < 256; i++) begin
         h += int'(pwm_out);
         t += int'(sample_taken_out);
         step();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cnt     = 0;
      clk_in  = 1'b0;
      rst_in  = 1'b1;
      sample_in       = 16'h0000;
      sample_valid_in = 1'b0;
      vol_shift_in    = 2'd0;
      mute_in         = 1'b0;

      // Reset, with a strobe during reset that must be discarded.
      step();
      step();
      send(16'h7FFF);
      step();
      check("rst_pwm", int'(pwm_out), 0);
      check("rst_sd", int'(audio_sd_out), 0);
      check("rst_taken", int'(sample_taken_out), 0);
      check("rst_overrun", int'(overrun_out), 0);

      rst_in = 1'b0;
      cnt    = 0;
      check("sd_at_release", int'(audio_sd_out), 0);
      step();
      check("sd_after_release", int'(audio_sd_out), 1);
      measure(hi, tk);
      check("mid_hi", hi, 128);
      check("mid_taken", tk, 0);

      // Full-scale positive.
      wait_to(10);
      send(16'h7FFF);
      wait_to(0);
      check("max_taken", int'(sample_taken_out), 1);
      step();
      measure(hi, tk);
      check("max_hi", hi, 255);
      check("max_taken_once", tk, 0);

      // Full-scale negative.
      wait_to(20);
      send(16'h8000);
      wait_to(0);
      check("min_taken", int'(sample_taken_out), 1);
      step();
      measure(hi, tk);
      check("min_hi", hi, 0);

      // 0x4000 >>> 1 = 0x2000 -> 0xA000 -> 160.
      vol_shift_in = 2'd1;
      wait_to(20);
      send(16'h4000);
      wait_to(0);
      check("vol_taken", int'(sample_taken_out), 1);
      vol_shift_in = 2'd0;
      step();
      measure(hi, tk);
      check("vol_hi", hi, 160);

      // Strobe on the load cycle: 0x1000 -> 144 loaded first, then 0xC000 -> 64.
      wait_to(50);
      send(16'h1000);
      wait_to(255);
      send(16'hC000);
      check("coincide_taken", int'(sample_taken_out), 1);
      check("coincide_overrun", int'(overrun_out), 0);
      step();
      measure(hi, tk);
      check("coincide_old_hi", hi, 144);
      check("coincide_second_load", tk, 1);
      measure(hi, tk);
      check("coincide_new_hi", hi, 64);
      check("coincide_overrun_after", int'(overrun_out), 0);

      // Two strobes in one period: overrun, newer sample 0x2000 -> 160 wins.
      wait_to(30);
      send(16'h1000);
      check("ovr_first", int'(overrun_out), 0);
      wait_to(40);
      send(16'h2000);
      check("ovr_set", int'(overrun_out), 1);
      wait_to(1);
      measure(hi, tk);
      check("ovr_hi", hi, 160);
      check("ovr_sticky", int'(overrun_out), 1);

      // Mute mid-period; a sample sent while muted still loads.
      wait_to(100);
      check("premute_pwm", int'(pwm_out), 1);
      mute_in = 1'b1;
      step();
      check("mute_pwm", int'(pwm_out), 0);
      check("mute_sd", int'(audio_sd_out), 0);
      wait_to(120);
      send(16'hE000);
      wait_to(0);
      check("mute_taken", int'(sample_taken_out), 1);
      step();
      measure(hi, tk);
      check("mute_hi", hi, 0);
      wait_to(0);
      mute_in = 1'b0;
      step();
      measure(hi, tk);
      check("unmute_hi", hi, 96);
      check("unmute_sd", int'(audio_sd_out), 1);

      // Reset mid-period with a sample pending: duty returns to midscale.
      wait_to(60);
      send(16'h7FFF);
      wait_to(80);
      rst_in = 1'b1;
      step();
      step();
      check("rst2_overrun", int'(overrun_out), 0);
      check("rst2_pwm", int'(pwm_out), 0);
      check("rst2_sd", int'(audio_sd_out), 0);
      rst_in = 1'b0;
      cnt    = 0;
      step();
      measure(hi, tk);
      check("rst2_hi", hi, 128);
      check("rst2_taken", tk, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/audio_pwm_out.md
AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, PWM resolution in bits; PWM period is 2^PWM_BITS clk_in cycles.
REQ-002 SHALL have port clk_in, input, 1, the single system clock.
REQ-003 SHALL have port rst_in, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port sample_in, input, 16, signed two's-complement mixed audio sample from the four-tone summer.
REQ-005 SHALL have port sample_valid_in, input, 1, one-cycle strobe marking sample_in valid.
REQ-006 SHALL have port vol_shift_in, input, 2, attenuation as an arithmetic right shift of 0-3 bits.
REQ-007 SHALL have port mute_in, input, 1, forces silent output while high.
REQ-008 SHALL have port pwm_out, output, 1, registered PWM audio waveform.
REQ-009 SHALL have port audio_sd_out, output, 1, amplifier enable; high = amplifier on.
REQ-010 SHALL have port sample_taken_out, output, 1, one-cycle strobe when the pending sample is loaded into the active duty register.
REQ-011 SHALL have port overrun_out, output, 1, sticky flag set when a pending sample is overwritten before it is loaded.

Function
REQ-012 SHALL run a free-running counter pwm_count, 0 to 2^PWM_BITS-1, that increments every cycle and wraps to 0.
REQ-013 SHALL use a double buffer:
- On sample_valid_in, write sample_in into the pending register and set pending_full.
- The active duty SHALL change only at a period boundary.
REQ-014 SHALL perform a load on the cycle pwm_count == 2^PWM_BITS-1 when pending_full is set:
- active_duty <= convert(pending).
- pending_full is cleared.
- sample_taken_out pulses high for that cycle.
REQ-015 SHALL compute convert(x) as follows:
- s = x >>> vol_shift_in (sign-preserving).
- u = s with its bit 15 inverted (offset binary, 16 bits unsigned).
- duty = u[15:16-PWM_BITS].
- vol_shift_in is sampled on the load cycle.
REQ-016 SHALL handle sample_valid_in coinciding with a load as follows:
- The load takes the old pending value.
- The new sample becomes pending and pending_full stays 1.
- No overrun is flagged.
REQ-017 SHALL set overrun_out when sample_valid_in arrives while pending_full=1 and no load occurs that cycle; the newer sample overwrites pending.
REQ-018 SHALL clear overrun_out only on reset.
REQ-019 SHALL register pwm_out as (pwm_count < active_duty), giving exactly one cycle of latency from counter to output.
REQ-020 SHALL produce these duty extremes:
- duty 0 gives pwm_out constantly low.
- duty 2^PWM_BITS-1 gives pwm_out high for 2^PWM_BITS-1 cycles of every period.
REQ-021 SHALL handle mute_in as follows:
- While mute_in is high, pwm_out is registered 0 and audio_sd_out is registered 0, both with one cycle of latency.
- The counter, capture, load and overrun logic continue to operate unaffected.
REQ-022 SHALL register audio_sd_out = !mute_in every cycle after reset.

Reset
REQ-023 SHALL set the following on a cycle with rst_in high:
- pwm_count=0, pending_full=0, pending=0.
- active_duty=2^(PWM_BITS-1) (midscale silence).
- pwm_out=0, audio_sd_out=0, sample_taken_out=0, overrun_out=0.
REQ-024 SHALL give rst_in priority over every other input, and SHALL discard any sample captured before reset, including on reset mid-period.
REQ-025 SHALL, after rst_in is released, begin PWM with pwm_count=0 and midscale duty until the first load.

Verification (PWM_BITS=8)
REQ-026 SHALL check reset release with no samples -> pwm_out high for exactly 128 of every 256 cycles; audio_sd_out=1 from the second cycle after release.
REQ-027 SHALL check sample_in=0x7FFF and vol_shift_in=0 -> duty 255; next full period has 255 high and 1 low; sample_taken_out pulses once at count 255.
REQ-028 SHALL check sample_in=0x8000 -> duty 0 (pwm_out never high); then sample_in=0x4000 with vol_shift_in=1 -> 0x2000 -> 0xA000 -> duty 160 high per period.
REQ-029 SHALL check two strobes (0x1000 then 0x2000) within one period -> overrun_out=1 and persists; loaded duty=0xA0 (from 0x2000).
REQ-030 SHALL check a strobe on the exact load cycle while pending_full -> old sample loaded, new sample loaded at the following boundary, overrun_out stays 0.
REQ-031 SHALL check mute_in asserted mid-period -> pwm_out=0 and audio_sd_out=0 one cycle later with the counter still advancing; rst_in mid-period with pending_full -> pending discarded and duty returns to 128.
